program_sequencer: RTL and testbench



---
 rtl/program_sequencer.sv | 97 +++++++++
 tb/tb_program_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Instruction-issue stage: fetches from a combinational-read program ROM, holds each
// executable op for its executor step count, then drops to NOP; HALT/JMP/JZ resolve here.
module program_sequencer #(
  parameter int A = 4
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Start,
  output logic [A-1:0]  ProgAddr,
  input  logic [19:0]   ProgData,
  output logic [19:0]   OpCode,
  input  logic          ExecDone,
  input  logic          ZeroFlag,
  output logic [A-1:0]  PC,
  output logic          Busy,
  output logic          Halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [3:0]    op;
  logic [A-1:0]  target;
  logic [A-1:0]  pc_inc;

  assign ProgAddr = PC;
  assign op       = ProgData[19:16];
  assign target   = ProgData[A-1:0];
  assign pc_inc   = PC + 1'b1;

  // Executor step count minus one; the EXEC countdown ends when it reaches zero.
  function automatic logic [2:0] steps_m1(input logic [3:0] code);
    case (code)
      4'h1:                      steps_m1 = 3'd1;
      4'h2, 4'h3, 4'h5, 4'h9,
      4'hB, 4'hC, 4'hD:          steps_m1 = 3'd2;
      4'h4, 4'h6, 4'h7, 4'hA:    steps_m1 = 3'd3;
      4'h8:                      steps_m1 = 3'd4;
      default:                   steps_m1 = 3'd0;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state  <= IDLE;
      PC     <= '0;
      OpCode <= '0;
      Busy   <= 1'b0;
      Halted <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          OpCode <= '0;
          if (Start && ExecDone) begin
            PC     <= '0;
            Halted <= 1'b0;
            Busy   <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          OpCode <= '0;
          // Stall until the executor reports it has finished the previous op.
          if (ExecDone) begin
            case (op)
              4'h0: begin
                Busy   <= 1'b0;
                Halted <= 1'b1;
                state  <= HALTED;
              end
              4'hE: PC <= target;
              4'hF: PC <= ZeroFlag ? target : pc_inc;
              default: begin
                OpCode <= ProgData;
                PC     <= pc_inc;
                cnt    <= steps_m1(op);
                state  <= EXEC;
              end
            endcase
          end
        end
        EXEC: begin
          // NOP lands on the same edge as the executor's final step.
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            OpCode <= '0;
            state  <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues expected issue runs and halts,
// a negedge monitor measures OpCode runs / Halted rises and compares.
module tb_program_sequencer;

  localparam int A = 4;

  logic          Clock = 1'b0;
  logic          ResetN, Start, ExecDone, ZeroFlag;
  logic [A-1:0]  ProgAddr, PC;
  logic [19:0]   ProgData, OpCode;
  logic          Busy, Halted;
  logic [19:0]   rom [16];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit          is_halt;
    logic [19:0] val;
    int          len;
  } exp_t;
  exp_t q[$];

  program_sequencer #(.A(A)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .ProgAddr(ProgAddr),
    .ProgData(ProgData), .OpCode(OpCode), .ExecDone(ExecDone), .ZeroFlag(ZeroFlag),
    .PC(PC), .Busy(Busy), .Halted(Halted)
  );

  assign ProgData = rom[ProgAddr];

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_issue(input logic [19:0] v, input int n);
    exp_t e;
    e.is_halt = 1'b0; e.val = v; e.len = n;
    q.push_back(e);
  endtask

  task automatic push_halt(input logic [A-1:0] pc);
    exp_t e;
    e.is_halt = 1'b1; e.val = 20'(pc); e.len = 0;
    q.push_back(e);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) rom[i] = 20'h0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!(Halted && q.size() == 0) && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    chk({name, "_drained"}, 32'(n < 200), 32'd1);
  endtask

  // Monitor: an OpCode run ends when the value changes; a halt is a Halted rising edge.
  initial begin
    logic [19:0] prev_op = 20'h0;
    logic        prev_halt = 1'b0;
    int          run_len = 0;
    exp_t        e;
    forever begin
      @(negedge Clock);
      if (mon_en) begin
        if (prev_op != 20'h0 && OpCode != prev_op) begin
          if (q.size() == 0) begin
            chk("unexpected_issue", 32'(prev_op), 32'h0);
          end else begin
            e = q.pop_front();
            chk("issue_kind", 32'(e.is_halt), 32'd0);
            chk("issue_op", 32'(prev_op), 32'(e.val));
            chk("issue_len", 32'(run_len), 32'(e.len));
            chk("bubble", 32'(OpCode), 32'h0);
          end
        end
        if (OpCode != 20'h0) run_len = (OpCode == prev_op) ? run_len + 1 : 1;
        if (Halted && !prev_halt) begin
          if (q.size() == 0) begin
            chk("unexpected_halt", 32'(Halted), 32'd0);
          end else begin
            e = q.pop_front();
            chk("halt_kind", 32'(e.is_halt), 32'd1);
            chk("halt_pc", 32'(PC), 32'(e.val));
            chk("halt_busy", 32'(Busy), 32'd0);
          end
        end
        prev_op = OpCode;
        prev_halt = Halted;
      end
    end
  end

  initial begin
    int n;
    ResetN = 1'b0; Start = 1'b0; ExecDone = 1'b1; ZeroFlag = 1'b0;
    rom_clear();
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_opcode", 32'(OpCode), 32'h0);
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_addr", 32'(ProgAddr), 32'h0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    ResetN = 1'b1;
    mon_en = 1'b1;
    @(posedge Clock); #1;

    // LOAD_CONST then HALT
    rom[0] = 20'h10005; rom[1] = 20'h00000;
    push_issue(20'h10005, 2); push_halt(4'd1);
    start_pulse();
    wait_halt("t1");

    // Same program with the executor holding off the first fetch
    push_issue(20'h10005, 2); push_halt(4'd1);
    start_pulse();
    ExecDone = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("stall_opcode", 32'(OpCode), 32'h0);
    chk("stall_pc", 32'(PC), 32'h0);
    ExecDone = 1'b1;
    wait_halt("stall");

    // MUL_REG, LOAD_REG, HALT; a mid-run Start must be ignored
    rom_clear();
    rom[0] = 20'h80102; rom[1] = 20'h30001; rom[2] = 20'h00000;
    push_issue(20'h80102, 5); push_issue(20'h30001, 3); push_halt(4'd2);
    start_pulse();
    repeat (3) @(posedge Clock);
    #1;
    start_pulse();
    wait_halt("t2");

    // JMP 3 then HALT
    rom_clear();
    rom[0] = 20'hE0003;
    push_halt(4'd3);
    start_pulse();
    @(posedge Clock); #1;
    chk("jmp_pc", 32'(PC), 32'd3);
    chk("jmp_halted_early", 32'(Halted), 32'd0);
    @(posedge Clock); #1;
    chk("jmp_halt_at_3", 32'(Halted), 32'd1);
    wait_halt("t3");

    // JZ taken / not taken
    rom_clear();
    rom[0] = 20'hF0005;
    ZeroFlag = 1'b1;
    push_halt(4'd5);
    start_pulse();
    wait_halt("jz_taken");
    ZeroFlag = 1'b0;
    push_halt(4'd1);
    start_pulse();
    wait_halt("jz_not_taken");

    // Wrap from address 15 to 0
    rom_clear();
    rom[0] = 20'hE000F; rom[15] = 20'h10001;
    push_issue(20'h10001, 2); push_halt(4'd0);
    start_pulse();
    n = 0;
    while (PC != 4'd15 && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("wrap_reach15", 32'(PC), 32'd15);
    rom[0] = 20'h00000;
    wait_halt("wrap");

    // Reset in cycle 2 of MUL_REG EXEC, then rerun
    rom_clear();
    rom[0] = 20'h80102; rom[1] = 20'h30001; rom[2] = 20'h00000;
    push_issue(20'h80102, 2);
    start_pulse();
    @(posedge Clock); #1;
    chk("pre_rst_issue", 32'(OpCode), 32'h80102);
    @(posedge Clock); #1;
    ResetN = 1'b0;
    @(posedge Clock); #1;
    ResetN = 1'b1;
    chk("mid_rst_opcode", 32'(OpCode), 32'h0);
    chk("mid_rst_pc", 32'(PC), 32'h0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_halted", 32'(Halted), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    chk("idle_pc", 32'(PC), 32'h0);
    chk("idle_busy", 32'(Busy), 32'd0);
    push_issue(20'h80102, 5); push_issue(20'h30001, 3); push_halt(4'd2);
    start_pulse();
    wait_halt("rerun");

    repeat (3) @(posedge Clock);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
